// File: rtl/sum_accumulator.sv
// Frame accumulator: sums CNT upstream adder results per frame and presents
// the frame total on a valid/ready output, holding it until downstream accepts.
module sum_accumulator #(
    parameter  int N     = 4,
    parameter  int CNT   = 4,
    localparam int ACC_W = N + 1 + ((CNT > 1) ? $clog2(CNT) : 0),
    localparam int CW    = $clog2(CNT + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N:0]       in_sum,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             clear,
    output logic [ACC_W-1:0] out_total,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CW-1:0]    count
);

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    state_t           state_reg, state_next;
    logic [ACC_W-1:0] acc_reg, acc_next;
    logic [ACC_W-1:0] total_reg, total_next;
    logic [CW-1:0]    count_reg, count_next;

    // Running sum including the word currently offered; ACC_W is wide enough
    // for CNT maximal words, so this never wraps.
    logic [ACC_W-1:0] acc_sum;
    // The word being offered would be the last one of the frame.
    logic             last_word;

    assign acc_sum   = acc_reg + ACC_W'(in_sum);
    assign last_word = (count_reg == CW'(CNT - 1));

    // State and datapath registers; reset clears everything without a clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ACCUM;
            acc_reg   <= '0;
            total_reg <= '0;
            count_reg <= '0;
        end else begin
            state_reg <= state_next;
            acc_reg   <= acc_next;
            total_reg <= total_next;
            count_reg <= count_next;
        end
    end

    // Next-state and datapath updates; clear overrides every other event and
    // leaves the last published total untouched.
    always_comb begin
        state_next = state_reg;
        acc_next   = acc_reg;
        total_next = total_reg;
        count_next = count_reg;
        if (clear) begin
            state_next = ACCUM;
            acc_next   = '0;
            count_next = '0;
        end else begin
            case (state_reg)
                ACCUM: begin
                    if (in_valid) begin
                        if (last_word) begin
                            total_next = acc_sum;
                            acc_next   = '0;
                            count_next = '0;
                            state_next = HOLD;
                        end else begin
                            acc_next   = acc_sum;
                            count_next = count_reg + CW'(1);
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        state_next = ACCUM;
                    end
                end
                default: begin
                    state_next = ACCUM;
                end
            endcase
        end
    end

    // Ready is gated by reset so nothing is offered while the block is held.
    assign in_ready  = rst_n && (state_reg == ACCUM) && !clear;
    assign out_valid = (state_reg == HOLD);
    assign out_total = total_reg;
    assign count     = count_reg;

endmodule

// File: tb/tb_sum_accumulator.sv
// Directed bench for sum_accumulator: a vector table for the CNT=4 instance
// plus hand-written sequences for async reset and a CNT=1 instance.
module tb_sum_accumulator;

    logic clk = 1'b0;
    logic rst_n;

    // CNT=4 instance signals
    logic [4:0] in_sum;
    logic       in_valid;
    logic       in_ready;
    logic       clear;
    logic [6:0] out_total;
    logic       out_valid;
    logic       out_ready;
    logic [2:0] count;

    // CNT=1 instance signals
    logic [4:0] s1_in_sum;
    logic       s1_in_valid;
    logic       s1_in_ready;
    logic       s1_clear;
    logic [4:0] s1_out_total;
    logic       s1_out_valid;
    logic       s1_out_ready;
    logic [0:0] s1_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sum_accumulator #(.N(4), .CNT(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_sum    (in_sum),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .clear     (clear),
        .out_total (out_total),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .count     (count)
    );

    sum_accumulator #(.N(4), .CNT(1)) dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_sum    (s1_in_sum),
        .in_valid  (s1_in_valid),
        .in_ready  (s1_in_ready),
        .clear     (s1_clear),
        .out_total (s1_out_total),
        .out_valid (s1_out_valid),
        .out_ready (s1_out_ready),
        .count     (s1_count)
    );

    typedef struct {
        logic [4:0] in_sum;
        logic       in_valid;
        logic       out_ready;
        logic       clear;
        logic       exp_in_ready;   // before the edge
        logic       exp_out_valid;  // after the edge
        logic [6:0] exp_total;
        logic [2:0] exp_count;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic [4:0] s, input logic v, input logic ordy,
                                input logic clr, input logic erdy, input logic eov,
                                input logic [6:0] etot, input logic [2:0] ecnt);
        vec_t r;
        r.in_sum = s; r.in_valid = v; r.out_ready = ordy; r.clear = clr;
        r.exp_in_ready = erdy; r.exp_out_valid = eov; r.exp_total = etot; r.exp_count = ecnt;
        vecs.push_back(r);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Called at a falling edge: drive, check ready, clock, check registered outputs.
    task automatic apply(input vec_t r, input int idx);
        in_sum    = r.in_sum;
        in_valid  = r.in_valid;
        out_ready = r.out_ready;
        clear     = r.clear;
        #1;
        check($sformatf("v%0d in_ready", idx), {31'd0, in_ready}, {31'd0, r.exp_in_ready});
        @(posedge clk);
        #1;
        check($sformatf("v%0d out_valid", idx), {31'd0, out_valid}, {31'd0, r.exp_out_valid});
        check($sformatf("v%0d out_total", idx), {25'd0, out_total}, {25'd0, r.exp_total});
        check($sformatf("v%0d count", idx), {29'd0, count}, {29'd0, r.exp_count});
        $display("v%0d in=%0d vld=%0d ordy=%0d clr=%0d -> ov=%0d total=%0d count=%0d",
                 idx, r.in_sum, r.in_valid, r.out_ready, r.clear, out_valid, out_total, count);
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        in_sum = '0; in_valid = 1'b0; out_ready = 1'b0; clear = 1'b0;
        s1_in_sum = '0; s1_in_valid = 1'b0; s1_out_ready = 1'b0; s1_clear = 1'b0;

        //   in  v ordy clr | rdy ov total cnt
        // basic frame 1,2,3,4 -> 10
        add(5'd1,  1, 1, 0,  1, 0, 7'd0,   3'd1);
        add(5'd2,  1, 1, 0,  1, 0, 7'd0,   3'd2);
        add(5'd3,  1, 1, 0,  1, 0, 7'd0,   3'd3);
        add(5'd4,  1, 1, 0,  1, 1, 7'd10,  3'd0);
        add(5'd0,  0, 1, 0,  0, 0, 7'd10,  3'd0);
        // max-value frame 31 x4 -> 124
        add(5'd31, 1, 1, 0,  1, 0, 7'd10,  3'd1);
        add(5'd31, 1, 1, 0,  1, 0, 7'd10,  3'd2);
        add(5'd31, 1, 1, 0,  1, 0, 7'd10,  3'd3);
        add(5'd31, 1, 0, 0,  1, 1, 7'd124, 3'd0);
        // backpressure: 5 cycles out_ready=0 with input offered
        for (int i = 0; i < 5; i++) add(5'd7, 1, 0, 0, 0, 1, 7'd124, 3'd0);
        add(5'd7,  1, 1, 0,  0, 0, 7'd124, 3'd0);
        // next frame 3,3,3,3 -> 12, starts right after handshake
        add(5'd3,  1, 1, 0,  1, 0, 7'd124, 3'd1);
        add(5'd3,  1, 1, 0,  1, 0, 7'd124, 3'd2);
        add(5'd3,  1, 1, 0,  1, 0, 7'd124, 3'd3);
        add(5'd3,  1, 1, 0,  1, 1, 7'd12,  3'd0);
        add(5'd0,  0, 1, 0,  0, 0, 7'd12,  3'd0);
        // clear mid-frame after 5,6, then 1,1,1,1 -> 4
        add(5'd5,  1, 1, 0,  1, 0, 7'd12,  3'd1);
        add(5'd6,  1, 1, 0,  1, 0, 7'd12,  3'd2);
        add(5'd9,  1, 1, 1,  0, 0, 7'd12,  3'd0);
        add(5'd1,  1, 1, 0,  1, 0, 7'd12,  3'd1);
        add(5'd1,  1, 1, 0,  1, 0, 7'd12,  3'd2);
        add(5'd1,  1, 1, 0,  1, 0, 7'd12,  3'd3);
        add(5'd1,  1, 0, 0,  1, 1, 7'd4,   3'd0);
        // clear in HOLD drops out_valid, total kept
        add(5'd0,  0, 0, 1,  0, 0, 7'd4,   3'd0);
        // idle cycle mid-frame holds state: 5,_,5,5,5 -> 20
        add(5'd5,  1, 1, 0,  1, 0, 7'd4,   3'd1);
        add(5'd9,  0, 1, 0,  1, 0, 7'd4,   3'd1);
        add(5'd5,  1, 1, 0,  1, 0, 7'd4,   3'd2);
        add(5'd5,  1, 1, 0,  1, 0, 7'd4,   3'd3);
        add(5'd5,  1, 0, 0,  1, 1, 7'd20,  3'd0);

        // reset state
        @(negedge clk);
        check("rst out_valid", {31'd0, out_valid}, 32'd0);
        check("rst out_total", {25'd0, out_total}, 32'd0);
        check("rst count", {29'd0, count}, 32'd0);
        check("rst in_ready", {31'd0, in_ready}, 32'd0);
        check("rst s1 in_ready", {31'd0, s1_in_ready}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) apply(vecs[i], i);

        // async reset while in HOLD, between clock edges
        #2;
        rst_n = 1'b0;
        #1;
        check("async out_valid", {31'd0, out_valid}, 32'd0);
        check("async out_total", {25'd0, out_total}, 32'd0);
        check("async count", {29'd0, count}, 32'd0);
        check("async in_ready", {31'd0, in_ready}, 32'd0);
        $display("async reset -> ov=%0d total=%0d count=%0d", out_valid, out_total, count);
        @(negedge clk);
        rst_n = 1'b1;
        begin
            vec_t r;
            r.in_valid = 1'b1; r.out_ready = 1'b1; r.clear = 1'b0; r.in_sum = 5'd2;
            r.exp_in_ready = 1'b1;
            for (int k = 0; k < 4; k++) begin
                r.exp_out_valid = (k == 3);
                r.exp_total     = (k == 3) ? 7'd8 : 7'd0;
                r.exp_count     = (k == 3) ? 3'd0 : 3'(k + 1);
                apply(r, 100 + k);
            end
        end

        // CNT=1 instance: each transfer is a frame
        s1_in_sum = 5'd17; s1_in_valid = 1'b1; s1_out_ready = 1'b0;
        #1;
        check("s1 in_ready", {31'd0, s1_in_ready}, 32'd1);
        @(posedge clk); #1;
        check("s1 out_valid", {31'd0, s1_out_valid}, 32'd1);
        check("s1 out_total", {27'd0, s1_out_total}, 32'd17);
        check("s1 count", {31'd0, s1_count}, 32'd0);
        $display("s1 in=17 -> ov=%0d total=%0d", s1_out_valid, s1_out_total);
        @(negedge clk);
        s1_in_sum = 5'd31; s1_out_ready = 1'b1;
        #1;
        check("s1 hold in_ready", {31'd0, s1_in_ready}, 32'd0);
        @(posedge clk); #1;
        check("s1 hs out_valid", {31'd0, s1_out_valid}, 32'd0);
        check("s1 hs out_total", {27'd0, s1_out_total}, 32'd17);
        @(posedge clk); #1;
        check("s1 f2 out_valid", {31'd0, s1_out_valid}, 32'd1);
        check("s1 f2 out_total", {27'd0, s1_out_total}, 32'd31);
        $display("s1 in=31 -> ov=%0d total=%0d", s1_out_valid, s1_out_total);
        s1_in_valid = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
